dram_word_port: RTL and testbench

DRAM_WORD_PORT -- requirements
Module: dram_word_port

---
 rtl/dram_word_port_pkg.sv | 32 +++
 rtl/dram_word_port_mem.sv | 35 +++
 rtl/dram_word_port.sv | 209 ++++++++++++++++++++
 tb/tb_dram_word_port.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_word_port_pkg.sv
// dram_word_port_pkg
//   Shared definitions for the byte-cell memory word port:
//   - state_t     : access FSM states
//   - SZ_*        : encodings of the 2-bit size field
//   - beat_count  : size field -> number of MEM_W beats (0 for reserved)
package dram_word_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RLAST,
    DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  // beats is the full-word beat count of the instantiating port.
  function automatic int unsigned beat_count(input logic [1:0] sz,
                                             input int unsigned beats);
    case (sz)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return beats;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/dram_word_port_mem.sv
// dram_byte_mem
//   DEPTH x MEM_W single-port cell array. Synchronous write, registered
//   read (data for addr appears one cycle later). The array and the read
//   register carry no reset so the array maps onto block RAM.
// Ports:
//   clk   - clock
//   we    - write enable for this cycle
//   addr  - cell address (shared by read and write)
//   wdata - write data
//   rdata - registered read data of the address presented last cycle
module dram_byte_mem #(
  parameter int MEM_W  = 8,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [MEM_W-1:0]  wdata,
  output logic [MEM_W-1:0]  rdata
);

  logic [MEM_W-1:0] mem_array [DEPTH];
  logic [MEM_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
    rdata_reg <= mem_array[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dram_word_port.sv
// dram_word_port
//   Multi-beat word access port in front of a byte-wide cell memory.
//   A request (1, 2 or BEATS beats) is split into one memory access per
//   cycle, little-endian. Reads are reassembled into data_out, optionally
//   sign-extended from the top byte read.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   en, w_en, r_en    - request strobe and direction qualifiers
//   size, sign_ext    - beat count select, sign-extend short reads
//   addr, c_bus       - base byte address, write data
//   data_out          - assembled read word (changes only when a read ends)
//   busy, done, err   - access in progress, completion pulse, reject pulse
module dram_word_port
  import dram_word_port_pkg::*;
#(
  parameter  int BUS_W  = 32,
  parameter  int MEM_W  = 8,
  parameter  int ADDR_W = 12,
  parameter  int DEPTH  = 4096,
  localparam int BEATS  = BUS_W / MEM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  c_bus,
  output logic [BUS_W-1:0]  data_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int LANE_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t            state_reg, state_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic [BEAT_W-1:0] n_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              sext_reg;
  logic [BUS_W-1:0]  wdata_reg;
  logic [BUS_W-1:0]  data_out_reg;
  logic              err_reg;

  int unsigned       req_beats;
  logic [31:0]       req_last;
  logic              req_bad;
  logic              accept;
  logic              start;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;

  logic [MEM_W-1:0]  wr_lane [BEATS];
  logic [MEM_W-1:0]  rd_lane_reg [BEATS];
  logic [BUS_W-1:0]  rd_word;
  logic [LANE_W-1:0] beat_lane;
  logic [LANE_W-1:0] cap_lane;
  logic              ext_bit;

  // ---------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------
  always_comb begin
    req_beats = beat_count(size, BEATS);
    req_last  = 32'(addr) + req_beats - 32'd1;
    req_bad   = (w_en == r_en) || (size == SZ_RSVD) ||
                (req_last > 32'(DEPTH - 1));
  end

  assign accept = en && (state_reg == IDLE);
  assign start  = accept && !req_bad;

  // ---------------------------------------------------------------
  // FSM: next state and status outputs
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy      = 1'b0;
        beat_next = '0;
        if (start) begin
          state_next = w_en ? WRITE : READ;
        end
      end
      WRITE: begin
        if (beat_reg == n_reg - BEAT_W'(1)) begin
          state_next = DONE;
          beat_next  = '0;
        end else begin
          beat_next = beat_reg + BEAT_W'(1);
        end
      end
      READ: begin
        // Keep counting past the last issue so that beat_reg-1 always
        // names the lane whose data is arriving from the memory.
        beat_next = beat_reg + BEAT_W'(1);
        if (beat_reg == n_reg - BEAT_W'(1)) begin
          state_next = RLAST;
        end
      end
      RLAST: begin
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        beat_next  = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      n_reg        <= '0;
      addr_reg     <= '0;
      sext_reg     <= 1'b0;
      wdata_reg    <= '0;
      data_out_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      err_reg   <= accept && req_bad;
      if (start) begin
        n_reg     <= BEAT_W'(req_beats);
        addr_reg  <= addr;
        sext_reg  <= sign_ext;
        wdata_reg <= c_bus;
      end
      // Last byte arrives during RLAST; the finished word is visible in DONE.
      if (state_reg == RLAST) begin
        data_out_reg <= rd_word;
      end
    end
  end

  // ---------------------------------------------------------------
  // Memory datapath
  // ---------------------------------------------------------------
  assign beat_lane = beat_reg[LANE_W-1:0];
  assign cap_lane  = beat_lane - LANE_W'(1);
  assign mem_we    = (state_reg == WRITE);
  assign mem_addr  = addr_reg + ADDR_W'(beat_reg);
  assign mem_wdata = wr_lane[beat_lane];

  // Lanes 0..N-2 are parked here; lane N-1 is taken straight from the
  // memory output in RLAST.
  always_ff @(posedge clk) begin
    if ((state_reg == READ) && (beat_reg != '0)) begin
      rd_lane_reg[cap_lane] <= mem_rdata;
    end
  end

  // In RLAST the memory output is byte N-1, whose MSB is bit MEM_W*N-1.
  assign ext_bit = sext_reg & mem_rdata[MEM_W-1];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
      logic [MEM_W-1:0] lane_val;

      assign wr_lane[gi] = wdata_reg[gi*MEM_W +: MEM_W];

      always_comb begin
        if (BEAT_W'(gi) == n_reg - BEAT_W'(1)) begin
          lane_val = mem_rdata;
        end else if (BEAT_W'(gi) < n_reg) begin
          lane_val = rd_lane_reg[gi];
        end else begin
          lane_val = {MEM_W{ext_bit}};
        end
      end

      assign rd_word[gi*MEM_W +: MEM_W] = lane_val;
    end
  endgenerate

  dram_byte_mem #(
    .MEM_W (MEM_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign data_out = data_out_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_dram_word_port.sv
// tb_dram_word_port
//   Directed self-checking bench for dram_word_port. One task per scenario,
//   each with its own hand-computed expectations.
module tb_dram_word_port;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        w_en;
  logic        r_en;
  logic [1:0]  size;
  logic        sign_ext;
  logic [11:0] addr;
  logic [31:0] c_bus;
  logic [31:0] data_out;
  logic        busy;
  logic        done;
  logic        err;

  int total  = 0;
  int passed = 0;

  dram_word_port #(
    .BUS_W (32),
    .MEM_W (8),
    .ADDR_W(12),
    .DEPTH (4096)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .w_en    (w_en),
    .r_en    (r_en),
    .size    (size),
    .sign_ext(sign_ext),
    .addr    (addr),
    .c_bus   (c_bus),
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a request (caller is at a negedge), lets the next rising edge
  // sample it, then drops the strobe 1 time unit after that edge.
  task automatic start_req(input logic w, input logic r, input logic [1:0] sz,
                           input logic sx, input logic [11:0] a,
                           input logic [31:0] d);
    en = 1'b1; w_en = w; r_en = r; size = sz; sign_ext = sx; addr = a; c_bus = d;
    @(posedge clk);
    #1;
    en = 1'b0; w_en = 1'b0; r_en = 1'b0;
  endtask

  // Latency = number of rising edges from accept up to the one that sees
  // done high (done seen at the negedge after edge k => latency k+1).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      $display("FAIL done_timeout: got no done within 20 cycles, want done");
    end
  endtask

  task automatic do_write(input logic [1:0] sz, input logic [11:0] a,
                          input logic [31:0] d, output int lat);
    @(negedge clk);
    start_req(1'b1, 1'b0, sz, 1'b0, a, d);
    wait_done(lat);
    $display("write size=%0d addr=%03h data=%08h latency=%0d", sz, a, d, lat);
  endtask

  task automatic do_read(input logic [1:0] sz, input logic sx,
                         input logic [11:0] a, output int lat);
    @(negedge clk);
    start_req(1'b0, 1'b1, sz, sx, a, 32'h0);
    wait_done(lat);
    $display("read  size=%0d sext=%0d addr=%03h data_out=%08h latency=%0d",
             sz, sx, a, data_out, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; w_en = 1'b0; r_en = 1'b0;
    size = 2'd0; sign_ext = 1'b0; addr = '0; c_bus = '0;
    repeat (3) @(negedge clk);
    total++; if (data_out !== 32'h0) $display("FAIL reset_data_out: got %08h want 00000000", data_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_word_write_read();
    int lat;
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_write(2'd2, 12'h010, 32'hDEADBEEF, lat);
    total++; if (lat !== 5) $display("FAIL word_write_latency: got %0d want 5", lat); else passed++;
    total++; if (data_out !== 32'h0) $display("FAIL write_keeps_data_out: got %08h want 00000000", data_out); else passed++;
    for (int k = 0; k < 4; k++) begin
      do_read(2'd0, 1'b0, 12'h010 + 12'(k), lat);
      total++;
      if (data_out !== {24'h0, exp_b[k]})
        $display("FAIL cell_%03h: got %08h want %08h", 12'h010 + 12'(k), data_out, {24'h0, exp_b[k]});
      else passed++;
    end
    do_read(2'd2, 1'b0, 12'h010, lat);
    total++; if (data_out !== 32'hDEADBEEF) $display("FAIL word_read_data: got %08h want deadbeef", data_out); else passed++;
    total++; if (lat !== 6) $display("FAIL word_read_latency: got %0d want 6", lat); else passed++;
  endtask

  task automatic test_sign_ext();
    int lat;
    do_write(2'd0, 12'h020, 32'h00000080, lat);
    do_read(2'd0, 1'b1, 12'h020, lat);
    total++; if (data_out !== 32'hFFFFFF80) $display("FAIL byte_sext1: got %08h want ffffff80", data_out); else passed++;
    do_read(2'd0, 1'b0, 12'h020, lat);
    total++; if (data_out !== 32'h00000080) $display("FAIL byte_sext0: got %08h want 00000080", data_out); else passed++;
    do_write(2'd0, 12'h021, 32'h0000007F, lat);
    total++; if (data_out !== 32'h00000080) $display("FAIL data_out_hold: got %08h want 00000080", data_out); else passed++;
  endtask

  task automatic test_half_read();
    int lat;
    do_write(2'd1, 12'h030, 32'h00001234, lat);
    do_read(2'd1, 1'b0, 12'h030, lat);
    total++; if (data_out !== 32'h00001234) $display("FAIL half_read_data: got %08h want 00001234", data_out); else passed++;
    total++; if (lat !== 4) $display("FAIL half_read_latency: got %0d want 4", lat); else passed++;
    do_read(2'd1, 1'b1, 12'h030, lat);
    total++; if (data_out !== 32'h00001234) $display("FAIL half_sext_pos: got %08h want 00001234", data_out); else passed++;
    do_write(2'd1, 12'h032, 32'h00008001, lat);
    do_read(2'd1, 1'b1, 12'h032, lat);
    total++; if (data_out !== 32'hFFFF8001) $display("FAIL half_sext_neg: got %08h want ffff8001", data_out); else passed++;
  endtask

  task automatic test_errors();
    int lat;
    // Last two cells are a legal half access.
    do_write(2'd1, 12'hFFE, 32'h00005AA5, lat);
    total++; if (lat !== 3) $display("FAIL top_half_write_latency: got %0d want 3", lat); else passed++;
    @(negedge clk);
    start_req(1'b1, 1'b0, 2'd2, 1'b0, 12'hFFE, 32'hCAFEF00D);
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL overflow_err: got %b want 1", err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL overflow_busy: got %b want 0", busy); else passed++;
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", err); else passed++;
    do_read(2'd1, 1'b0, 12'hFFE, lat);
    total++; if (data_out !== 32'h00005AA5) $display("FAIL overflow_no_write: got %08h want 00005aa5", data_out); else passed++;
    @(negedge clk);
    start_req(1'b1, 1'b1, 2'd0, 1'b0, 12'h000, 32'h0);
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL both_en_err: got %b want 1", err); else passed++;
    start_req(1'b0, 1'b0, 2'd0, 1'b0, 12'h000, 32'h0);
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL no_en_err: got %b want 1", err); else passed++;
    start_req(1'b1, 1'b0, 2'd3, 1'b0, 12'h000, 32'h0);
    @(negedge clk);
    total++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL size3_err: got err=%b busy=%b want err=1 busy=0", err, busy); else passed++;
    $display("reject checks done at addr=ffe / w_en=r_en / size=3");
  endtask

  task automatic test_busy_ignore();
    int lat;
    int dcount;
    int ecount;
    @(negedge clk);
    start_req(1'b0, 1'b1, 2'd2, 1'b0, 12'h010, 32'h0);
    @(negedge clk);
    // Now inside READ: a conflicting write request must be ignored.
    en = 1'b1; w_en = 1'b1; size = 2'd2; addr = 12'h010; c_bus = 32'h0;
    @(posedge clk);
    #1;
    en = 1'b0; w_en = 1'b0;
    dcount = 0;
    ecount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (err) ecount++;
    end
    $display("read  size=2 addr=010 with en pulsed while busy, dones=%0d", dcount);
    total++; if (dcount !== 1) $display("FAIL busy_single_done: got %0d want 1", dcount); else passed++;
    total++; if (ecount !== 0) $display("FAIL busy_no_err: got %0d want 0", ecount); else passed++;
    do_read(2'd2, 1'b0, 12'h010, lat);
    total++; if (data_out !== 32'hDEADBEEF) $display("FAIL busy_write_ignored: got %08h want deadbeef", data_out); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    do_write(2'd2, 12'h050, 32'h01020304, lat);
    total++; if (busy !== 1'b1) $display("FAIL busy_in_done: got %b want 1", busy); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL idle_after_done: got %b want 0", busy); else passed++;
    start_req(1'b0, 1'b1, 2'd2, 1'b0, 12'h050, 32'h0);
    wait_done(lat);
    $display("read  size=2 sext=0 addr=050 data_out=%08h latency=%0d", data_out, lat);
    total++; if (lat !== 6) $display("FAIL b2b_latency: got %0d want 6", lat); else passed++;
    total++; if (data_out !== 32'h01020304) $display("FAIL b2b_data: got %08h want 01020304", data_out); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int dcount;
    do_write(2'd2, 12'h040, 32'hA5A5A5A5, lat);
    @(negedge clk);
    start_req(1'b1, 1'b0, 2'd2, 1'b0, 12'h040, 32'h11223344);
    @(posedge clk);   // beat 0 stored
    @(posedge clk);   // beat 1 stored
    #1;
    rst_n = 1'b0;     // during beat 2
    #1;
    $display("reset asserted during beat 2 of write addr=040 data=11223344");
    total++; if (data_out !== 32'h0) $display("FAIL mid_reset_data_out: got %08h want 00000000", data_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mid_reset_done: got %b want 0", done); else passed++;
    total++; if (err !== 1'b0) $display("FAIL mid_reset_err: got %b want 0", err); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    total++; if (dcount !== 0) $display("FAIL mid_reset_no_done: got %0d want 0", dcount); else passed++;
    do_read(2'd2, 1'b0, 12'h040, lat);
    total++; if (data_out !== 32'hA5A53344) $display("FAIL mid_reset_cells: got %08h want a5a53344", data_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_sign_ext();
    test_half_read();
    test_errors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
